// File: rtl/fuz_response_checker.sv
`default_nettype none
// ============================================================================
// Module   : fuz_response_checker
// Brief    : Compares golden and revised netlist outputs on each valid strobe,
//            latches the first divergence (sample index and XOR mask) and
//            optionally compacts the revised outputs into a MISR signature.
// Options  : FUZ_CHECK_MISR_EN -- when defined, enables the MISR signature;
//            when undefined, signature is held at zero.
// Revision : 1.0 - initial release
// ============================================================================
module fuz_response_checker #(
  parameter int          WIDTH       = 11,
  parameter int          NUM_SAMPLES = 1024,
  parameter int          CNT_W       = 16,
  parameter int          SIG_W       = 32,
  parameter logic [31:0] POLY        = 32'h04C11DB7,
  parameter logic [31:0] SEED        = 32'hFFFFFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             valid,
  input  logic [WIDTH-1:0] gold,
  input  logic [WIDTH-1:0] rev,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [CNT_W-1:0] fail_cycle,
  output logic [WIDTH-1:0] fail_mask,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [SIG_W-1:0] signature
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index of the final sample of a run; accepting it ends the run.
  localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(NUM_SAMPLES - 1);

  state_t           r_state;
  logic [WIDTH-1:0] w_diff;
  logic             w_hit;
  logic             w_accept;
  logic             w_launch;

  assign w_diff   = gold ^ rev;
  assign w_hit    = |w_diff;
  assign w_accept = (r_state == RUN) && valid;
  assign w_launch = ((r_state == IDLE) || (r_state == DONE)) && start;

  // Run-control FSM with registered status, counter and first-fail capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      mismatch   <= 1'b0;
      fail_cycle <= '0;
      fail_mask  <= '0;
      sample_cnt <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state    <= RUN;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            mismatch   <= 1'b0;
            fail_cycle <= '0;
            fail_mask  <= '0;
            sample_cnt <= '0;
          end
        end
        RUN: begin
          if (valid) begin
            // Counter stops at NUM_SAMPLES; the run ends on that same edge.
            if (sample_cnt != CNT_W'(NUM_SAMPLES))
              sample_cnt <= sample_cnt + 1'b1;
            // Only the first divergence is recorded.
            if (w_hit && !mismatch) begin
              mismatch   <= 1'b1;
              fail_cycle <= sample_cnt;
              fail_mask  <= w_diff;
            end
            if (sample_cnt == c_last_idx) begin
              r_state <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= !(mismatch || w_hit);
            end
          end
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

`ifdef FUZ_CHECK_MISR_EN
  localparam logic [SIG_W-1:0] c_poly = SIG_W'(POLY);
  localparam logic [SIG_W-1:0] c_seed = SIG_W'(SEED);

  logic [SIG_W-1:0] w_misr_next;

  assign w_misr_next = (signature << 1)
                     ^ (signature[SIG_W-1] ? c_poly : '0)
                     ^ SIG_W'(rev);

  // MISR: seeded on run launch, compacts revised outputs on accepted samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      signature <= '0;
    else if (w_launch)
      signature <= c_seed;
    else if (w_accept)
      signature <= w_misr_next;
  end
`else
  // Signature compaction is compiled out; the result port reads as zero.
  logic w_unused_cfg;
  assign w_unused_cfg = ^{POLY, SEED, w_launch, w_accept};
  assign signature    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fuz_response_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_fuz_response_checker
// Brief    : Directed self-checking bench for fuz_response_checker with
//            WIDTH=11 and NUM_SAMPLES=4. Expected signature depends on
//            FUZ_CHECK_MISR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fuz_response_checker;

  localparam int WIDTH       = 11;
  localparam int NUM_SAMPLES = 4;
  localparam int CNT_W       = 16;
  localparam int SIG_W       = 32;

`ifdef FUZ_CHECK_MISR_EN
  localparam logic [31:0] c_exp_seed = 32'hFFFFFFFF;
  localparam logic [31:0] c_exp_sig1 = 32'hFB3EE249;
`else
  localparam logic [31:0] c_exp_seed = 32'h0;
  localparam logic [31:0] c_exp_sig1 = 32'h0;
`endif

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             valid;
  logic [WIDTH-1:0] gold;
  logic [WIDTH-1:0] rev;
  logic             busy;
  logic             done;
  logic             pass;
  logic             mismatch;
  logic [CNT_W-1:0] fail_cycle;
  logic [WIDTH-1:0] fail_mask;
  logic [CNT_W-1:0] sample_cnt;
  logic [SIG_W-1:0] signature;

  int vectors;
  int miscompares;

  fuz_response_checker #(
    .WIDTH      (WIDTH),
    .NUM_SAMPLES(NUM_SAMPLES),
    .CNT_W      (CNT_W),
    .SIG_W      (SIG_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .valid     (valid),
    .gold      (gold),
    .rev       (rev),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .mismatch  (mismatch),
    .fail_cycle(fail_cycle),
    .fail_mask (fail_mask),
    .sample_cnt(sample_cnt),
    .signature (signature)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [WIDTH-1:0] g, input logic [WIDTH-1:0] r);
    valid = 1'b1;
    gold  = g;
    rev   = r;
    tick();
    valid = 1'b0;
  endtask

  task automatic launch();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busy"},       32'(busy),       32'h0);
    chk({tag, ".done"},       32'(done),       32'h0);
    chk({tag, ".pass"},       32'(pass),       32'h0);
    chk({tag, ".mismatch"},   32'(mismatch),   32'h0);
    chk({tag, ".fail_cycle"}, 32'(fail_cycle), 32'h0);
    chk({tag, ".fail_mask"},  32'(fail_mask),  32'h0);
    chk({tag, ".sample_cnt"}, 32'(sample_cnt), 32'h0);
    chk({tag, ".signature"},  signature,       32'h0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    // ---- Reset with random inputs ----
    rst_n = 1'b0;
    start = 1'($urandom);
    valid = 1'($urandom);
    gold  = WIDTH'($urandom);
    rev   = WIDTH'($urandom);
    repeat (3) tick();
    chk_all_zero("reset");
    start = 1'b0;
    valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // ---- Clean run; valid in the start cycle is ignored ----
    start = 1'b1;
    valid = 1'b1;
    gold  = 11'h155;
    rev   = 11'h155;
    tick();
    start = 1'b0;
    valid = 1'b0;
    chk("clean.busy_after_start", 32'(busy), 32'h1);
    chk("clean.cnt_after_start",  32'(sample_cnt), 32'h0);
    chk("clean.seed",             signature, c_exp_seed);
    sample(11'h155, 11'h155);
    sample(11'h155, 11'h155);
    sample(11'h155, 11'h155);
    chk("clean.cnt3",  32'(sample_cnt), 32'h3);
    chk("clean.done3", 32'(done), 32'h0);
    sample(11'h155, 11'h155);
    chk("clean.done",     32'(done),       32'h1);
    chk("clean.busy",     32'(busy),       32'h0);
    chk("clean.pass",     32'(pass),       32'h1);
    chk("clean.mismatch", 32'(mismatch),   32'h0);
    chk("clean.cnt",      32'(sample_cnt), 32'h4);
    // valid in DONE is ignored; counter holds at NUM_SAMPLES
    sample(11'h155, 11'h000);
    chk("clean.cnt_hold",      32'(sample_cnt), 32'h4);
    chk("clean.mismatch_hold", 32'(mismatch),   32'h0);

    // ---- First-fail latch ----
    launch();
    chk("ff.cleared_pass", 32'(pass), 32'h0);
    chk("ff.cleared_done", 32'(done), 32'h0);
    chk("ff.cleared_cnt",  32'(sample_cnt), 32'h0);
    sample(11'h2A3, 11'h2A3);
    sample(11'h2A3, 11'h2A3);
    chk("ff.mismatch_pre", 32'(mismatch), 32'h0);
    sample(11'h2A3, 11'h2A3 ^ 11'h004);
    chk("ff.mismatch_set", 32'(mismatch), 32'h1);
    chk("ff.cycle_early",  32'(fail_cycle), 32'h2);
    sample(11'h2A3, 11'h2A3 ^ 11'h100);
    chk("ff.fail_cycle", 32'(fail_cycle), 32'h2);
    chk("ff.fail_mask",  32'(fail_mask),  32'h004);
    chk("ff.done",       32'(done),       32'h1);
    chk("ff.pass",       32'(pass),       32'h0);

    // ---- Gaps and start ignored in RUN (also clears previous failure) ----
    launch();
    chk("gap.mismatch_cleared", 32'(mismatch),   32'h0);
    chk("gap.mask_cleared",     32'(fail_mask),  32'h0);
    chk("gap.cycle_cleared",    32'(fail_cycle), 32'h0);
    sample(11'h0F0, 11'h0F0);
    tick();
    sample(11'h0F0, 11'h0F0);
    launch();
    chk("gap.cnt_after_start", 32'(sample_cnt), 32'h2);
    chk("gap.busy_kept",       32'(busy),       32'h1);
    sample(11'h0F0, 11'h0F0);
    tick();
    chk("gap.cnt3",  32'(sample_cnt), 32'h3);
    chk("gap.done3", 32'(done),       32'h0);
    sample(11'h0F0, 11'h0F0);
    chk("gap.done", 32'(done),       32'h1);
    chk("gap.pass", 32'(pass),       32'h1);
    chk("gap.cnt",  32'(sample_cnt), 32'h4);

    // ---- Reset mid-run ----
    launch();
    sample(11'h3FF, 11'h3FE);
    sample(11'h3FF, 11'h3FF);
    chk("rst.pre_mismatch", 32'(mismatch), 32'h1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst.async");
    tick();
    chk_all_zero("rst.idle");
    rst_n = 1'b1;
    tick();
    launch();
    sample(11'h001, 11'h001);
    sample(11'h002, 11'h002);
    sample(11'h004, 11'h004);
    sample(11'h008, 11'h008);
    chk("rst.rerun_done", 32'(done),     32'h1);
    chk("rst.rerun_pass", 32'(pass),     32'h1);
    chk("rst.rerun_mm",   32'(mismatch), 32'h0);

    // ---- MISR single step from seed ----
    launch();
    chk("misr.seed", signature, c_exp_seed);
    sample(11'h000, 11'h000);
    chk("misr.sig1", signature, c_exp_sig1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete within time budget");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/fuz_response_checker.md
# fuz_response_checker

Output-side checker for fuzz-generated netlist benches. It samples the primary outputs of a golden netlist and of its re-synthesised or revised counterpart on every valid strobe, and compares them bit for bit. It latches the first divergence (sample index and XOR mask) and optionally compacts the revised outputs into a MISR signature. It sits between the DUT pair's output buffers and the bench scoreboard, and receives the stimulus driver's `valid` strobe.

## Interface

Parameters:
- `WIDTH`, default 11: number of compared output bits per netlist.
- `NUM_SAMPLES`, default 1024: samples per run. Legal range is 1 to 2^CNT_W−1.
- `CNT_W`, default 16: width of the sample counter and of `fail_cycle`.
- `SIG_W`, default 32: MISR width. Must be ≥ WIDTH.
- `POLY`, default 32'h04C11DB7: MISR feedback polynomial.
- `SEED`, default 32'hFFFFFFFF: MISR value loaded on `start`.

Ports:
- `clk`, input, 1: sole clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: begin a new run. Accepted in IDLE or DONE.
- `valid`, input, 1: `gold` and `rev` hold a sample this cycle.
- `gold`, input, WIDTH: golden netlist outputs.
- `rev`, input, WIDTH: revised netlist outputs.
- `busy`, output, 1: high while in RUN.
- `done`, output, 1: high while in DONE.
- `pass`, output, 1: high in DONE only if no mismatch occurred.
- `mismatch`, output, 1: sticky first-divergence flag.
- `fail_cycle`, output, CNT_W: sample index (0-based) of the first mismatch.
- `fail_mask`, output, WIDTH: `gold ^ rev` at the first mismatch.
- `sample_cnt`, output, CNT_W: accepted samples in the current run.
- `signature`, output, SIG_W: MISR state.

## Operation

- FSM has three states: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE → RUN on `start`. This clears `mismatch`, `fail_cycle`, `fail_mask`, `sample_cnt` and `pass`, and loads `signature` with SEED. `valid` is ignored in the `start` cycle.
- RUN:
  - `valid` high accepts one sample and increments `sample_cnt`.
  - If `gold != rev` and `mismatch` is low: set `mismatch`, `fail_cycle <= sample_cnt`, `fail_mask <= gold ^ rev`.
  - Later mismatches never overwrite these fields.
  - `start` is ignored in RUN.
- RUN → DONE on the edge that accepts sample number NUM_SAMPLES. On that edge `pass <=` NOT(`mismatch` OR the current sample's mismatch).
- DONE holds all results. `valid` is ignored. `start` re-enters RUN with the same clearing as from IDLE.
- All outputs are registered. No combinational path from inputs to outputs.
- Reset value of every output is 0, with `signature` = 0. Asserting `rst_n` low mid-run aborts immediately to IDLE.

## Timing

- Result fields are visible one cycle after the sampling edge.
- `done` and `pass` rise on the edge that accepts the final sample.
- `busy` rises on the edge after `start` is sampled and falls on the same edge `done` rises.
- Throughput is one sample per cycle. `valid` gaps stall counting with no penalty.
- `sample_cnt` saturates at NUM_SAMPLES and never wraps.

## Configuration

- `FUZ_CHECK_MISR_EN` defined: on every accepted sample, `signature <= (signature << 1) ^ (signature[SIG_W-1] ? POLY : 0) ^ zero_extend(rev)`.
- `FUZ_CHECK_MISR_EN` undefined: MISR logic is omitted and `signature` is tied to 0. The `start` seeding is also absent.

## Test plan

Test plan uses WIDTH=11 and NUM_SAMPLES=4.

- Reset: `rst_n` = 0 with random inputs → all outputs 0, `busy` = 0, `done` = 0.
- Clean run: `start`, then 4 valid samples with `gold` = `rev` = 11'h155 → `done` = 1, `pass` = 1, `mismatch` = 0, `sample_cnt` = 4.
- First-fail latch: samples 0–3, where sample 2 has `rev` = `gold` ^ 11'h004 and sample 3 has `rev` = `gold` ^ 11'h100 → `fail_cycle` = 2, `fail_mask` = 11'h004, `pass` = 0 at `done`.
- Gaps and start-in-RUN: `valid` high on alternate cycles plus a `start` pulse mid-run → `done` follows the 4th valid only, and no counters are cleared.
- Reset mid-run: `rst_n` low after 2 samples → IDLE next cycle with all outputs 0; a new `start` and 4 samples then yields `pass` = 1.
- MISR (`FUZ_CHECK_MISR_EN`): `start`, then one sample with `rev` = 0 → `signature` = 32'hFB3EE249. With the macro undefined → `signature` = 0.
